// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for a 16-bit ALU with own error checks and a 32-bit accumulator
module alu_op_sequencer #(
  parameter int LATENCY = 2,
  parameter int MAX_OP  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_use_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [5:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] acc,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [5:0]  sel_q, sel_d;
  logic        err_q, err_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d, acc_q, acc_d;
  logic [15:0] a_sel;
  logic [16:0] sum;
  logic        illegal, op_err, wide;
  logic [31:0] res;
  always_comb begin
    a_sel   = req_use_acc ? acc_q[15:0] : req_a;
    sum     = {1'b0, a_sel} + {1'b0, req_b};
    illegal = req_op > 6'(MAX_OP);
    op_err  = illegal
            | (req_op == 6'd4 && a_sel > 16'd12)
            | (req_op == 6'd5 && a_sel > 16'd22)
            | (req_op == 6'd6 && sum[16])
            | (req_op == 6'd7 && a_sel < req_b)
            | (req_op == 6'd9 && req_b == 16'd0);
    // factorial, exp and multiply produce full 32-bit results; the rest are 16-bit
    wide    = sel_q == 6'd4 || sel_q == 6'd5 || sel_q == 6'd8;
    res     = wide ? alu_out : {16'h0000, alu_out[15:0]};
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    acc_d      = acc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        a_d     = a_sel;
        b_d     = req_b;
        sel_d   = illegal ? 6'd0 : req_op;
        err_d   = op_err;
        cnt_d   = 4'(LATENCY - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        state_d    = RESP;
        rsp_err_d  = err_q;
        rsp_data_d = (err_q || sel_q == 6'd0) ? 32'd0 : res;
        acc_d      = err_q ? acc_q : (sel_q == 6'd0 ? 32'd0 : res);
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      acc_q      <= acc_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the sequencer against a behavioural ALU stand-in
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_use_acc = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [5:0]  alu_sel;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] acc;
  logic        busy;
  int errors = 0;
  int checks = 0;
  int lat;
  logic [31:0] d;
  logic        e;
  logic [5:0]  s;

  alu_op_sequencer #(.LATENCY(2), .MAX_OP(12)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Upper halves of 16-bit results carry junk so the sequencer's masking is exercised
  function automatic logic [31:0] alu_model(input logic [5:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] f;
    f = 32'd1;
    case (sel)
      6'd0: return 32'h1234_5678;
      6'd4: begin
        for (int i = 2; i <= int'(a) && i <= 12; i++) f = f * 32'(i);
        return f;
      end
      6'd6: return {16'hDEAD, a + b};
      6'd7: return {16'hBEEF, a - b};
      6'd8: return 32'(a) * 32'(b);
      6'd9: return b == 16'd0 ? 32'hFFFF_FFFF : {16'hCAFE, a / b};
      default: return {16'hABCD, a ^ b};
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input logic u,
                       output int l, output logic [31:0] dd, output logic ee, output logic [5:0] ss);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_acc = u;
    @(negedge clk);
    req_valid = 1'b0;
    ss = alu_sel;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    l = n - 1;
    dd = rsp_data;
    ee = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_acc", acc, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    do_op(6'd6, 16'd40, 16'd2, 1'b0, lat, d, e, s);
    chk("pre_acc", acc, 32'd42);
    // reset asserted while an op-8 request is in EXEC
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd8; req_a = 16'd5; req_b = 16'd6;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sel", 32'(alu_sel), 32'd8);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_acc", acc, 32'd0);
    chk("t1_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'd1);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_acc_after", acc, 32'd0);
    do_op(6'd6, 16'd3, 16'd4, 1'b0, lat, d, e, s);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_data", d, 32'd7);
    chk("t2_err", 32'(e), 32'd0);
    chk("t2_acc", acc, 32'd7);
    chk("t2_idle", 32'(req_ready), 32'd1);
    do_op(6'd6, 16'hFFFF, 16'd1, 1'b0, lat, d, e, s);
    chk("t3_err", 32'(e), 32'd1);
    chk("t3_data", d, 32'd0);
    chk("t3_acc", acc, 32'd7);
    do_op(6'd9, 16'd10, 16'd0, 1'b0, lat, d, e, s);
    chk("t4_div0_err", 32'(e), 32'd1);
    chk("t4_div0_data", d, 32'd0);
    chk("t4_div0_acc", acc, 32'd7);
    do_op(6'd4, 16'd13, 16'd0, 1'b0, lat, d, e, s);
    chk("t4_fact_err", 32'(e), 32'd1);
    chk("t4_fact_acc", acc, 32'd7);
    do_op(6'd13, 16'd1, 16'd2, 1'b0, lat, d, e, s);
    chk("t4_ill_err", 32'(e), 32'd1);
    chk("t4_ill_data", d, 32'd0);
    chk("t4_ill_sel", 32'(s), 32'd0);
    chk("t4_ill_latency", 32'(lat), 32'd2);
    chk("t4_ill_acc", acc, 32'd7);
    do_op(6'd8, 16'd100, 16'd3, 1'b1, lat, d, e, s);
    chk("t5_mul_data", d, 32'd21);
    chk("t5_mul_err", 32'(e), 32'd0);
    chk("t5_mul_alu_a", 32'(alu_a), 32'd7);
    chk("t5_mul_acc", acc, 32'd21);
    do_op(6'd0, 16'd9, 16'd9, 1'b0, lat, d, e, s);
    chk("t5_clr_data", d, 32'd0);
    chk("t5_clr_err", 32'(e), 32'd0);
    chk("t5_clr_acc", acc, 32'd0);
    // backpressure: rsp_ready held low for 5 cycles, with a request pending
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd6; req_a = 16'd10; req_b = 16'd20; req_use_acc = 1'b0;
    @(negedge clk);
    req_op = 6'd6; req_a = 16'd1; req_b = 16'd1;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("t6_data", rsp_data, 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t6_hold_data", rsp_data, 32'd30);
      chk("t6_hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t6_idle_ready", 32'(req_ready), 32'd1);
    chk("t6_idle_valid", 32'(rsp_valid), 32'd0);
    chk("t6_acc", acc, 32'd30);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_next_busy", 32'(busy), 32'd1);
    chk("t6_next_alu_a", 32'(alu_a), 32'd1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("t6_next_data", rsp_data, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_op(6'd4, 16'd12, 16'd0, 1'b0, lat, d, e, s);
    chk("b_fact12_data", d, 32'd479001600);
    chk("b_fact12_err", 32'(e), 32'd0);
    do_op(6'd7, 16'd3, 16'd3, 1'b0, lat, d, e, s);
    chk("b_sub_eq_data", d, 32'd0);
    chk("b_sub_eq_err", 32'(e), 32'd0);
    do_op(6'd7, 16'd2, 16'd3, 1'b0, lat, d, e, s);
    chk("b_sub_lt_err", 32'(e), 32'd1);
    do_op(6'd6, 16'hFFFE, 16'd1, 1'b0, lat, d, e, s);
    chk("b_add_max_data", d, 32'h0000_FFFF);
    chk("b_add_max_err", 32'(e), 32'd0);
    chk("b_add_max_acc", acc, 32'h0000_FFFF);
    do_op(6'd5, 16'd23, 16'd0, 1'b0, lat, d, e, s);
    chk("b_exp_err", 32'(e), 32'd1);
    chk("b_exp_acc", acc, 32'h0000_FFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
